// File: rtl/key_search_engine.sv
// Brute-force key recovery engine: sweeps candidate keys in ascending order and
// accepts the first key whose locked netlist output matches the oracle on every pattern.
module key_search_engine #(
  parameter int NIN  = 4,
  parameter int NKEY = 3,
  parameter int NOUT = 1,
  parameter int CW   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [NOUT-1:0] locked_y,
  input  logic [NOUT-1:0] oracle_y,
  output logic [NIN-1:0]  pat_out,
  output logic [NKEY-1:0] key_out,
  output logic            busy,
  output logic            done,
  output logic            found,
  output logic [NKEY-1:0] key_found,
  output logic [CW-1:0]   cycles
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [NIN-1:0]  PAT_MAX = '1;
  localparam logic [NKEY-1:0] KEY_MAX = '1;
  localparam logic [CW-1:0]   CYC_MAX = '1;

  state_t state, state_nx;
  logic   mismatch, last_pat, last_key;

  assign mismatch = (locked_y != oracle_y);
  assign last_pat = (pat_out == PAT_MAX);
  assign last_key = (key_out == KEY_MAX);

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Abort outranks both terminal conditions of the sweep.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        if (abort)                      state_nx = IDLE;
        else if (mismatch && last_key)  state_nx = DONE;
        else if (!mismatch && last_pat) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_out   <= '0;
      key_out   <= '0;
      found     <= 1'b0;
      key_found <= '0;
      cycles    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pat_out   <= '0;
            key_out   <= '0;
            found     <= 1'b0;
            key_found <= '0;
            cycles    <= '0;
          end
        end
        RUN: begin
          if (cycles != CYC_MAX) cycles <= cycles + CW'(1);
          if (abort) begin
            found <= 1'b0;
          end else if (mismatch) begin
            // A mismatch rejects the key; restart the pattern sweep on the next key.
            if (!last_key) begin
              key_out <= key_out + NKEY'(1);
              pat_out <= '0;
            end else begin
              found <= 1'b0;
            end
          end else if (!last_pat) begin
            pat_out <= pat_out + NIN'(1);
          end else begin
            found     <= 1'b1;
            key_found <= key_out;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_key_search_engine.sv
// Directed self-checking bench for key_search_engine with a parity oracle and
// per-scenario locked-netlist models.
module tb_key_search_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [0:0] locked_y, oracle_y;
  logic [3:0] pat_out;
  logic [2:0] key_out;
  logic       busy, done, found;
  logic [2:0] key_found;
  logic [15:0] cycles;

  int mode = 0;
  int errors = 0;
  int checks = 0;

  key_search_engine #(.NIN(4), .NKEY(3), .NOUT(1), .CW(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .locked_y(locked_y), .oracle_y(oracle_y),
    .pat_out(pat_out), .key_out(key_out), .busy(busy), .done(done),
    .found(found), .key_found(key_found), .cycles(cycles)
  );

  always #5 clk = ~clk;

  // Mode 0: key 5 correct, wrong keys fail at pattern 0; mode 1: never matches;
  // mode 2: key 7 correct, wrong keys fail only at pattern 15.
  always_comb begin
    oracle_y = ^pat_out;
    case (mode)
      0:       locked_y = oracle_y ^ 1'(key_out != 3'd5);
      1:       locked_y = ~oracle_y;
      default: locked_y = oracle_y ^ 1'(key_out != 3'd7 && pat_out == 4'd15);
    endcase
  end

  task automatic wait_done(output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) n++;
      @(negedge clk);
    end
  endtask

  task automatic run_search(output int n, output bit ok);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done(n, ok);
  endtask

  task automatic test_reset;
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %0b expected 0", done); end
    checks++; if (found !== 1'b0) begin errors++; $display("[TB] FAIL reset_found got %0b expected 0", found); end
    checks++; if (pat_out !== 4'd0) begin errors++; $display("[TB] FAIL reset_pat got %0d expected 0", pat_out); end
    checks++; if (key_out !== 3'd0) begin errors++; $display("[TB] FAIL reset_key got %0d expected 0", key_out); end
    checks++; if (cycles !== 16'd0) begin errors++; $display("[TB] FAIL reset_cycles got %0d expected 0", cycles); end
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_found_key5;
    int n; bit ok;
    mode = 0;
    run_search(n, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL k5_timeout got %0b expected 1", ok); end
    checks++; if (n !== 21) begin errors++; $display("[TB] FAIL k5_run_len got %0d expected 21", n); end
    checks++; if (found !== 1'b1) begin errors++; $display("[TB] FAIL k5_found got %0b expected 1", found); end
    checks++; if (key_found !== 3'd5) begin errors++; $display("[TB] FAIL k5_key got %0d expected 5", key_found); end
    checks++; if (cycles !== 16'd21) begin errors++; $display("[TB] FAIL k5_cycles got %0d expected 21", cycles); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL k5_busy got %0b expected 0", busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL k5_done_pulse got %0b expected 0", done); end
    checks++; if (found !== 1'b1) begin errors++; $display("[TB] FAIL k5_found_held got %0b expected 1", found); end
  endtask

  task automatic test_exhausted;
    int n; bit ok;
    mode = 1;
    run_search(n, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL exh_timeout got %0b expected 1", ok); end
    checks++; if (n !== 8) begin errors++; $display("[TB] FAIL exh_run_len got %0d expected 8", n); end
    checks++; if (found !== 1'b0) begin errors++; $display("[TB] FAIL exh_found got %0b expected 0", found); end
    checks++; if (key_found !== 3'd0) begin errors++; $display("[TB] FAIL exh_key got %0d expected 0", key_found); end
    checks++; if (cycles !== 16'd8) begin errors++; $display("[TB] FAIL exh_cycles got %0d expected 8", cycles); end
    checks++; if (key_out !== 3'd7) begin errors++; $display("[TB] FAIL exh_key_out got %0d expected 7", key_out); end
    @(negedge clk);
  endtask

  task automatic test_late_mismatch;
    int n; bit ok;
    mode = 2;
    run_search(n, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL late_timeout got %0b expected 1", ok); end
    checks++; if (cycles !== 16'd128) begin errors++; $display("[TB] FAIL late_cycles got %0d expected 128", cycles); end
    checks++; if (found !== 1'b1) begin errors++; $display("[TB] FAIL late_found got %0b expected 1", found); end
    checks++; if (key_found !== 3'd7) begin errors++; $display("[TB] FAIL late_key got %0d expected 7", key_found); end
    checks++; if (pat_out !== 4'd15) begin errors++; $display("[TB] FAIL late_pat got %0d expected 15", pat_out); end
    @(negedge clk);
  endtask

  task automatic test_abort;
    int n; bit ok; bit saw_done;
    mode = 0;
    saw_done = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (9) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    if (done) saw_done = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got %0b expected 0", busy); end
    checks++; if (cycles !== 16'd10) begin errors++; $display("[TB] FAIL abort_cycles got %0d expected 10", cycles); end
    checks++; if (found !== 1'b0) begin errors++; $display("[TB] FAIL abort_found got %0b expected 0", found); end
    checks++; if (pat_out !== 4'd4) begin errors++; $display("[TB] FAIL abort_pat got %0d expected 4", pat_out); end
    checks++; if (key_out !== 3'd5) begin errors++; $display("[TB] FAIL abort_key_out got %0d expected 5", key_out); end
    @(negedge clk);
    if (done) saw_done = 1'b1;
    checks++; if (saw_done !== 1'b0) begin errors++; $display("[TB] FAIL abort_no_done got %0b expected 0", saw_done); end
    run_search(n, ok);
    checks++; if (n !== 21) begin errors++; $display("[TB] FAIL abort_rerun_len got %0d expected 21", n); end
    checks++; if (key_found !== 3'd5) begin errors++; $display("[TB] FAIL abort_rerun_key got %0d expected 5", key_found); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    int n; bit ok;
    mode = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (11) @(negedge clk);
    checks++; if (cycles !== 16'd11) begin errors++; $display("[TB] FAIL rst_pre_cycles got %0d expected 11", cycles); end
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_async_busy got %0b expected 0", busy); end
    checks++; if (cycles !== 16'd0) begin errors++; $display("[TB] FAIL rst_async_cycles got %0d expected 0", cycles); end
    checks++; if (pat_out !== 4'd0) begin errors++; $display("[TB] FAIL rst_async_pat got %0d expected 0", pat_out); end
    checks++; if (key_out !== 3'd0) begin errors++; $display("[TB] FAIL rst_async_key got %0d expected 0", key_out); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL rst_async_done got %0b expected 0", done); end
    @(negedge clk) rst = 1'b0;
    run_search(n, ok);
    checks++; if (n !== 21) begin errors++; $display("[TB] FAIL rst_rerun_len got %0d expected 21", n); end
    checks++; if (found !== 1'b1) begin errors++; $display("[TB] FAIL rst_rerun_found got %0b expected 1", found); end
    checks++; if (key_found !== 3'd5) begin errors++; $display("[TB] FAIL rst_rerun_key got %0d expected 5", key_found); end
    @(negedge clk);
  endtask

  task automatic test_start_held;
    int n; bit ok;
    mode = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    wait_done(n, ok);
    checks++; if (n !== 21) begin errors++; $display("[TB] FAIL held_run_len got %0d expected 21", n); end
    checks++; if (found !== 1'b1) begin errors++; $display("[TB] FAIL held_found got %0b expected 1", found); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL held_idle_busy got %0b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL held_idle_done got %0b expected 0", done); end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL held_restart_busy got %0b expected 1", busy); end
    checks++; if (cycles !== 16'd0) begin errors++; $display("[TB] FAIL held_restart_cycles got %0d expected 0", cycles); end
    checks++; if (found !== 1'b0) begin errors++; $display("[TB] FAIL held_restart_found got %0b expected 0", found); end
    repeat (3) @(negedge clk);
    checks++; if (key_out !== 3'd3) begin errors++; $display("[TB] FAIL held_key_progress got %0d expected 3", key_out); end
    start = 1'b0;
    wait_done(n, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL held_timeout got %0b expected 1", ok); end
    checks++; if (cycles !== 16'd21) begin errors++; $display("[TB] FAIL held_cycles got %0d expected 21", cycles); end
    checks++; if (key_found !== 3'd5) begin errors++; $display("[TB] FAIL held_key got %0d expected 5", key_found); end
    @(negedge clk);
  endtask

  initial begin
    $display("[TB] starting key_search_engine bench");
    test_reset();
    test_found_key5();
    test_exhausted();
    test_late_mismatch();
    test_abort();
    test_reset_mid_run();
    test_start_held();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
